// File: rtl/adam_disk_pkg.sv
// Shared sector geometry, loader state encoding and image-size helper for the
// ADAM disk sector loader.
package adam_disk_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = 9;
  localparam int BUF_ADDR_W   = 9;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_REQ  = 3'd1;
  localparam state_t ST_RD_XFER = 3'd2;
  localparam state_t ST_WR_REQ  = 3'd3;
  localparam state_t ST_WR_XFER = 3'd4;

  // Whole sectors in an image; the counter is 32 bits wide.
  function automatic logic [31:0] sector_count(input logic [63:0] bytes);
    return bytes[SECTOR_SHIFT+31:SECTOR_SHIFT];
  endfunction

endpackage

// File: rtl/adam_sector_buf.sv
// 512x8 true dual-port sector buffer with registered reads.
// Port A faces the console, port B faces the SD block stream.
module adam_sector_buf
  import adam_disk_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [BUF_ADDR_W-1:0] a_addr_i,
  input  logic                  a_we_i,
  input  logic [7:0]            a_din_i,
  output logic [7:0]            a_dout_o,
  input  logic [BUF_ADDR_W-1:0] b_addr_i,
  input  logic                  b_we_i,
  input  logic [7:0]            b_din_i,
  output logic [7:0]            b_dout_o
);

  logic [7:0] mem [SECTOR_BYTES];
  logic [7:0] a_dout_d, a_dout_q;
  logic [7:0] b_dout_d, b_dout_q;

  // Storage itself is never reset; only the read registers are.
  always_ff @(posedge clk_i) begin
    if (a_we_i) mem[a_addr_i] <= a_din_i;
    if (b_we_i) mem[b_addr_i] <= b_din_i;
  end

  always_comb begin
    a_dout_d = mem[a_addr_i];
    b_dout_d = mem[b_addr_i];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

  assign a_dout_o = a_dout_q;
  assign b_dout_o = b_dout_q;

endmodule

// File: rtl/adam_sector_loader.sv
// Single-sector cache between the ADAM console disk port and an SD block
// interface, with optional write-back of dirty sectors.
module adam_sector_loader
  import adam_disk_pkg::*;
#(
  parameter bit WRITE_ENABLE = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  output logic        disk_present,
  input  logic [31:0] disk_sector,
  input  logic        disk_load,
  output logic        disk_sector_loaded,
  output logic        disk_error,
  input  logic [8:0]  disk_addr,
  input  logic        disk_wr,
  input  logic [7:0]  disk_din,
  output logic [7:0]  disk_data,
  input  logic        disk_flush
);

  state_t      state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic [31:0] req_q, req_d;
  logic [31:0] total_q, total_d;
  logic [31:0] sd_lba_q, sd_lba_d;
  logic [31:0] err_sec_q, err_sec_d;
  logic        valid_q, valid_d;
  logic        dirty_q, dirty_d;
  logic        present_q, present_d;
  logic        sd_rd_q, sd_rd_d;
  logic        sd_wr_q, sd_wr_d;
  logic        err_q, err_d;
  logic        err_hold_q, err_hold_d;
  logic        pend_q, pend_d;
  logic        abort_q, abort_d;
  logic        ack_q, mnt_q;

  logic        mount_rise, ack_fall, wb_ok, hit, loaded, bad, err_fire, buf_a_we;

  always_comb begin
    mount_rise = img_mounted && !mnt_q;
    ack_fall   = ack_q && !sd_ack;
    wb_ok      = WRITE_ENABLE && !img_readonly;
    hit        = valid_q && (disk_sector == lba_q);
    loaded     = (state_q == ST_IDLE) && hit;
    bad        = (disk_sector >= total_q) || !present_q;
    // A held load on a bad sector reports once, not every cycle.
    err_fire   = (state_q == ST_IDLE) && !mount_rise && disk_load && !hit && bad &&
                 !(err_hold_q && (disk_sector == err_sec_q));
    buf_a_we   = disk_wr && loaded && !mount_rise;
  end

  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    req_d      = req_q;
    total_d    = total_q;
    sd_lba_d   = sd_lba_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    present_d  = present_q;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    pend_d     = pend_q;
    abort_d    = abort_q;
    err_d      = err_fire;
    err_hold_d = disk_load && (err_hold_q || err_fire);
    err_sec_d  = err_fire ? disk_sector : err_sec_q;

    if (buf_a_we) dirty_d = 1'b1;

    // A mount during a transfer lets the handshake finish, then drops the result.
    if (mount_rise) begin
      total_d   = sector_count(img_size);
      present_d = |img_size;
      valid_d   = 1'b0;
      dirty_d   = 1'b0;
      if (state_q != ST_IDLE) abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!mount_rise) begin
          if (disk_load && !hit) begin
            if (!bad) begin
              req_d = disk_sector;
              if (dirty_q && wb_ok) begin
                state_d  = ST_WR_REQ;
                sd_wr_d  = 1'b1;
                sd_lba_d = lba_q;
                pend_d   = 1'b1;
              end else begin
                state_d  = ST_RD_REQ;
                sd_rd_d  = 1'b1;
                sd_lba_d = disk_sector;
                valid_d  = 1'b0;
                dirty_d  = 1'b0;
              end
            end
          end else if (disk_flush && !disk_load && valid_q && dirty_q && wb_ok) begin
            state_d  = ST_WR_REQ;
            sd_wr_d  = 1'b1;
            sd_lba_d = lba_q;
            pend_d   = 1'b0;
          end
        end
      end
      ST_RD_REQ: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          state_d = ST_RD_XFER;
        end
      end
      ST_RD_XFER: begin
        if (ack_fall) begin
          state_d = ST_IDLE;
          dirty_d = 1'b0;
          abort_d = 1'b0;
          if (abort_q || mount_rise) begin
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            lba_d   = req_q;
          end
        end
      end
      ST_WR_REQ: begin
        if (sd_ack) begin
          sd_wr_d = 1'b0;
          state_d = ST_WR_XFER;
        end
      end
      ST_WR_XFER: begin
        if (ack_fall) begin
          dirty_d = 1'b0;
          abort_d = 1'b0;
          pend_d  = 1'b0;
          if (abort_q || mount_rise) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else if (pend_q) begin
            state_d  = ST_RD_REQ;
            sd_rd_d  = 1'b1;
            sd_lba_d = req_q;
            valid_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      lba_q      <= '0;
      req_q      <= '0;
      total_q    <= '0;
      sd_lba_q   <= '0;
      err_sec_q  <= '0;
      valid_q    <= 1'b0;
      dirty_q    <= 1'b0;
      present_q  <= 1'b0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      err_q      <= 1'b0;
      err_hold_q <= 1'b0;
      pend_q     <= 1'b0;
      abort_q    <= 1'b0;
      ack_q      <= 1'b0;
      mnt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      req_q      <= req_d;
      total_q    <= total_d;
      sd_lba_q   <= sd_lba_d;
      err_sec_q  <= err_sec_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      present_q  <= present_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      err_q      <= err_d;
      err_hold_q <= err_hold_d;
      pend_q     <= pend_d;
      abort_q    <= abort_d;
      ack_q      <= sd_ack;
      mnt_q      <= img_mounted;
    end
  end

  adam_sector_buf u_buf (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .a_addr_i  (disk_addr),
    .a_we_i    (buf_a_we),
    .a_din_i   (disk_din),
    .a_dout_o  (disk_data),
    .b_addr_i  (sd_buff_addr),
    .b_we_i    ((state_q == ST_RD_XFER) && sd_buff_wr),
    .b_din_i   (sd_buff_dout),
    .b_dout_o  (sd_buff_din)
  );

  assign sd_lba             = sd_lba_q;
  assign sd_rd              = sd_rd_q;
  assign sd_wr              = sd_wr_q;
  assign disk_present       = present_q;
  assign disk_error         = err_q;
  assign disk_sector_loaded = loaded;

endmodule

// File: tb/tb_adam_sector_loader.sv
// Directed and randomized bench for adam_sector_loader against a behavioural
// model of the cached sector, its dirty state and the SD image contents.
module tb_adam_sector_loader;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = '0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_dout = '0;
  logic [7:0]  sd_buff_din;
  logic        disk_present;
  logic [31:0] disk_sector = '0;
  logic        disk_load = 1'b0;
  logic        disk_sector_loaded;
  logic        disk_error;
  logic [8:0]  disk_addr = '0;
  logic        disk_wr = 1'b0;
  logic [7:0]  disk_din = '0;
  logic [7:0]  disk_data;
  logic        disk_flush = 1'b0;

  adam_sector_loader dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .disk_present(disk_present), .disk_sector(disk_sector), .disk_load(disk_load),
    .disk_sector_loaded(disk_sector_loaded), .disk_error(disk_error),
    .disk_addr(disk_addr), .disk_wr(disk_wr), .disk_din(disk_din),
    .disk_data(disk_data), .disk_flush(disk_flush)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int unsigned seed_v;

  // Model: what the cached sector should hold, plus the SD image contents.
  logic [7:0]  exp_buf  [512];
  logic [7:0]  last_cap [512];
  logic        exp_valid = 1'b0;
  logic        exp_dirty = 1'b0;
  logic [31:0] exp_lba = '0;
  logic        ro = 1'b0;
  logic [7:0]  sd_over [longint];

  function automatic logic [7:0] sdByte(input logic [31:0] lba, input int addr);
    longint key;
    key = longint'(lba) * 512 + longint'(addr);
    if (sd_over.exists(key)) return sd_over[key];
    return 8'(lba * 32'd37 + 32'(addr) * 32'd11 + seed_v);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] sector, input logic load, input logic flush);
    disk_sector = sector;
    disk_load   = load;
    disk_flush  = flush;
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_sd_rd"}, sd_rd, 0);
    checkOutput({pfx, "_sd_wr"}, sd_wr, 0);
    checkOutput({pfx, "_sd_lba"}, sd_lba, 0);
    checkOutput({pfx, "_sd_buff_din"}, sd_buff_din, 0);
    checkOutput({pfx, "_present"}, disk_present, 0);
    checkOutput({pfx, "_loaded"}, disk_sector_loaded, 0);
    checkOutput({pfx, "_error"}, disk_error, 0);
    checkOutput({pfx, "_disk_data"}, disk_data, 0);
  endtask

  task automatic mountImage(input logic [63:0] size, input logic readonly);
    img_size = size;
    img_readonly = readonly;
    img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    tick(1);
    checkOutput("mount_present", disk_present, size != 0);
    exp_valid = 1'b0;
    exp_dirty = 1'b0;
    ro = readonly;
  endtask

  task automatic expectQuiet(input int n, input string tag);
    int busy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (sd_rd || sd_wr) busy++;
    end
    #1;
    checkOutput(tag, busy, 0);
  endtask

  // Acts as the SD side for one block request; write data lands in last_cap.
  task automatic sdServe(input int mount_at, output logic was_wr, output logic [31:0] lba,
                         output logic got);
    got = 1'b0;
    was_wr = 1'b0;
    lba = '0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_i);
      if (sd_rd || sd_wr) got = 1'b1;
    end
    if (!got) begin
      checkOutput("sd_request_timeout", 0, 1);
      return;
    end
    checkOutput("sd_rd_wr_exclusive", sd_rd & sd_wr, 0);
    was_wr = sd_wr;
    lba = sd_lba;
    repeat ($urandom_range(0, 2)) @(posedge clk_i);
    @(posedge clk_i);
    #1 sd_ack = 1'b1;
    tick(1);
    checkOutput("sd_req_dropped", sd_rd | sd_wr, 0);
    if (!was_wr) begin
      for (int i = 0; i < 512; i++) begin
        sd_buff_addr = 9'(i);
        sd_buff_dout = sdByte(lba, i);
        sd_buff_wr   = 1'b1;
        img_mounted  = (i == mount_at);
        tick(1);
      end
      sd_buff_wr  = 1'b0;
      img_mounted = 1'b0;
    end else begin
      for (int i = 0; i <= 512; i++) begin
        if (i > 0) last_cap[i-1] = sd_buff_din;
        if (i < 512) sd_buff_addr = 9'(i);
        tick(1);
      end
    end
    sd_ack = 1'b0;
    tick(1);
  endtask

  task automatic waitLoaded(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (disk_sector_loaded) seen = 1'b1;
    end
    #1;
    checkOutput(tag, seen, 1);
  endtask

  task automatic commitWriteBack(input string tag, input logic [31:0] lba_seen, input logic wr_seen);
    int mism = 0;
    checkOutput({tag, "_is_write"}, wr_seen, 1);
    checkOutput({tag, "_lba"}, lba_seen, exp_lba);
    for (int i = 0; i < 512; i++) if (last_cap[i] !== exp_buf[i]) mism++;
    checkOutput({tag, "_data"}, mism, 0);
    for (int i = 0; i < 512; i++) sd_over[longint'(exp_lba) * 512 + i] = exp_buf[i];
    exp_dirty = 1'b0;
  endtask

  task automatic doLoad(input logic [31:0] sector);
    logic w, g;
    logic [31:0] l;
    applyStimulus(sector, 1'b1, 1'b0);
    if (exp_valid && exp_lba == sector) begin
      tick(1);
      checkOutput("hit_loaded", disk_sector_loaded, 1);
      expectQuiet(4, "hit_no_sd_traffic");
    end else begin
      if (exp_valid && exp_dirty && !ro) begin
        sdServe(-1, w, l, g);
        commitWriteBack("wb", l, w);
      end
      sdServe(-1, w, l, g);
      checkOutput("rd_is_read", w, 0);
      checkOutput("rd_lba", l, sector);
      waitLoaded("rd_loaded");
      exp_valid = 1'b1;
      exp_dirty = 1'b0;
      exp_lba   = sector;
      for (int i = 0; i < 512; i++) exp_buf[i] = sdByte(sector, i);
    end
    disk_load = 1'b0;
    tick(1);
  endtask

  task automatic consoleWrite(input logic [8:0] addr, input logic [7:0] data);
    disk_addr = addr;
    disk_din  = data;
    disk_wr   = 1'b1;
    tick(1);
    disk_wr = 1'b0;
    if (exp_valid && exp_lba == disk_sector) begin
      exp_buf[addr] = data;
      exp_dirty = 1'b1;
    end
  endtask

  task automatic consoleRead(input logic [8:0] addr, input string tag);
    disk_addr = addr;
    tick(1);
    checkOutput(tag, disk_data, exp_buf[addr]);
  endtask

  task automatic doFlush();
    logic w, g;
    logic [31:0] l;
    disk_flush = 1'b1;
    tick(1);
    disk_flush = 1'b0;
    if (exp_valid && exp_dirty && !ro) begin
      sdServe(-1, w, l, g);
      commitWriteBack("flush", l, w);
    end else begin
      expectQuiet(8, "flush_no_sd_traffic");
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic w, g;
    logic [31:0] l;
    int errs, busy;
    logic seen;
    seed_v = $urandom;

    tick(3);
    checkResetOutputs("reset");
    reset_n_i = 1'b1;
    tick(2);

    mountImage(64'd163840, 1'b0);

    doLoad(32'd5);
    consoleRead(9'h1FF, "blk5_last_byte");
    checkOutput("blk5_last_byte_image", disk_data, sdByte(32'd5, 511));
    for (int i = 0; i < 4; i++) consoleRead(9'($urandom_range(0, 511)), "blk5_random_byte");

    consoleWrite(9'd3, 8'hA5);
    doLoad(32'd6);
    checkOutput("wb_byte3", last_cap[3], 8'hA5);

    applyStimulus(32'd320, 1'b1, 1'b0);
    errs = 0;
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (disk_error) errs++;
      if (sd_rd || sd_wr) busy++;
    end
    #1;
    checkOutput("oob_error_pulses", errs, 1);
    checkOutput("oob_no_sd_traffic", busy, 0);
    checkOutput("oob_not_loaded", disk_sector_loaded, 0);
    disk_load = 1'b0;
    tick(1);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0: doLoad(32'($urandom_range(0, 7)));
        1: consoleWrite(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
        2: if (exp_valid) consoleRead(9'($urandom_range(0, 511)), "rand_read");
        default: doFlush();
      endcase
    end
    if (exp_dirty) doFlush();

    mountImage(64'd163840, 1'b1);
    doLoad(32'd5);
    consoleWrite(9'd10, 8'h3C);
    doFlush();
    doLoad(32'd6);
    consoleRead(9'd10, "ro_discarded_read");

    mountImage(64'd163840, 1'b0);
    applyStimulus(32'd7, 1'b1, 1'b0);
    tick(1);
    disk_load = 1'b0;
    sdServe(100, w, l, g);
    checkOutput("abort_is_read", w, 0);
    checkOutput("abort_lba", l, 32'd7);
    tick(2);
    checkOutput("abort_not_loaded", disk_sector_loaded, 0);
    expectQuiet(6, "abort_idle_quiet");
    exp_valid = 1'b0;
    doLoad(32'd7);
    consoleRead(9'd100, "reread_byte100");

    consoleWrite(9'd0, 8'h11);
    applyStimulus(32'd2, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (sd_wr) seen = 1'b1;
    end
    #1;
    checkOutput("rst_wr_request", seen, 1);
    sd_ack = 1'b1;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      sd_buff_addr = 9'(i);
      tick(1);
    end
    reset_n_i = 1'b0;
    #1;
    checkResetOutputs("midwr_reset");
    tick(2);
    reset_n_i = 1'b1;
    sd_ack = 1'b0;
    disk_load = 1'b0;
    expectQuiet(20, "no_sd_after_reset");
    checkOutput("after_reset_not_loaded", disk_sector_loaded, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/adam_sector_loader.md
ADAM_SECTOR_LOADER -- requirements
Module: adam_sector_loader

Interface
REQ-001 SHALL have parameter WRITE_ENABLE, default 1, meaning dirty sectors are written back to SD (0 = buffer writes allowed, never written back).
REQ-002 SHALL have clk_i  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 SHALL have img_mounted  in  1, img_readonly  in  1, img_size  in  64: image mount pulse, read-only flag, image byte count.
REQ-005 SHALL have sd_lba  out  32, sd_rd  out  1, sd_wr  out  1, sd_ack  in  1: SD block request/acknowledge.
REQ-006 SHALL have sd_buff_addr  in  9, sd_buff_wr  in  1, sd_buff_dout  in  8, sd_buff_din  out  8: SD byte stream.
REQ-007 SHALL have disk_present  out  1, disk_sector  in  32, disk_load  in  1, disk_sector_loaded  out  1, disk_error  out  1: console sector control.
REQ-008 SHALL have disk_addr  in  9, disk_wr  in  1, disk_din  in  8 (console to buffer), disk_data  out  8 (buffer to console), disk_flush  in  1.

Function
REQ-009 SHALL hold one 512-byte sector buffer plus cached LBA, valid flag, dirty flag.
REQ-010 SHALL implement states IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER.
REQ-011 On img_mounted rising edge SHALL latch total_sectors = img_size[40:9], set disk_present = (img_size != 0), clear valid and dirty.
REQ-012 In IDLE with disk_load=1 and (!valid or disk_sector != cached LBA): sector >= total_sectors or !disk_present -> disk_error=1 for one cycle, no SD access; else dirty and write-back allowed -> WR_REQ for cached LBA; else -> RD_REQ for disk_sector.
REQ-013 disk_load SHALL be level-sensitive; held load on an already-cached sector SHALL cause no SD traffic.
REQ-014 RD_REQ/WR_REQ SHALL drive sd_lba and hold sd_rd/sd_wr high until sd_ack seen high, then drop it and enter RD_XFER/WR_XFER.
REQ-015 RD_XFER SHALL write sd_buff_dout to buffer[sd_buff_addr] on each sd_buff_wr; on sd_ack falling SHALL set valid, clear dirty, cached LBA = requested sector, go IDLE.
REQ-016 WR_XFER SHALL present buffer[sd_buff_addr] on sd_buff_din with 1-cycle registered latency; on sd_ack falling SHALL clear dirty, then go RD_REQ if a load is pending, else IDLE.
REQ-017 Write-back allowed = WRITE_ENABLE and !img_readonly; when not allowed, dirty SHALL be discarded at replacement.
REQ-018 disk_sector_loaded SHALL be 1 exactly when state IDLE, valid, and disk_sector == cached LBA (combinational on registered state).
REQ-019 disk_data SHALL equal buffer[disk_addr] one cycle after disk_addr is applied.
REQ-020 disk_wr while disk_sector_loaded SHALL write disk_din to buffer[disk_addr] and set dirty; disk_wr otherwise SHALL be ignored.
REQ-021 disk_flush in IDLE with valid, dirty, write-back allowed SHALL run WR_REQ/WR_XFER on cached LBA, then IDLE; otherwise no effect.
REQ-022 disk_load and disk_flush together SHALL be handled as load (load already writes back).
REQ-023 img_mounted during RD_*/WR_* SHALL complete the SD handshake (wait sd_ack low), then clear valid/dirty and return IDLE; no console write lands in the transfer.
REQ-024 sd_rd and sd_wr SHALL never be high simultaneously.

Reset
REQ-025 Reset SHALL force IDLE, sd_rd=0, sd_wr=0, sd_lba=0, sd_buff_din=0, disk_present=0, disk_sector_loaded=0, disk_error=0, disk_data=0, valid=0, dirty=0, total_sectors=0.
REQ-026 Buffer contents SHALL NOT be reset; reset mid-transfer SHALL abandon it with no write-back.

Structure
REQ-027 State enum and constants SECTOR_BYTES=512, SECTOR_SHIFT=9 SHALL live in shared package adam_disk_pkg.
REQ-028 Buffer SHALL be one sub-module adam_sector_buf: true dual-port 512x8, registered reads, port A console, port B SD.

Verification
REQ-029 Mount img_size=163840, disk_load sector 5 -> sd_rd with sd_lba=5, 512 bytes loaded, disk_sector_loaded=1, disk_data at addr 0x1FF matches byte 0x1FF of block 5.
REQ-030 Loaded sector 5, disk_wr addr 3 data 0xA5, disk_load sector 6 -> sd_wr lba 5 with sd_buff_din[3]=0xA5 first, then sd_rd lba 6.
REQ-031 img_size=163840, disk_load sector 320 -> disk_error pulse 1 cycle, no sd_rd/sd_wr, disk_sector_loaded=0.
REQ-032 img_readonly=1, dirty sector 5, disk_flush -> no sd_wr; disk_load sector 6 -> only sd_rd lba 6.
REQ-033 img_mounted pulse during RD_XFER -> handshake completes, disk_sector_loaded stays 0, next disk_load re-reads.
REQ-034 Reset asserted mid WR_XFER -> all outputs at reset values next edge, no further sd_wr.
